// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared FSM states, next-PC select codes and defaults for pc_sequencer
package pc_sequencer_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_EXEC, S_HALT} state_t;
  typedef enum logic [1:0] {NPC_INC, NPC_TGT, NPC_RET, NPC_HOLD} npc_t;
  localparam logic [7:0] RESET_VEC_DEF = 8'h00;
  localparam int STACK_DEPTH = 4;
endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: STACK_DEPTH-entry return-address stack; push/pop are ignored when full/empty
module pc_ret_stack
  import pc_sequencer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W = IDX_W + 1;
  logic [W-1:0] r_mem [STACK_DEPTH];
  logic [SP_W-1:0] r_sp;
  logic [SP_W-1:0] w_sp_dec;
  assign w_sp_dec = r_sp - SP_W'(1);
  assign full = r_sp == SP_W'(STACK_DEPTH);
  assign empty = r_sp == '0;
  assign dout = r_mem[w_sp_dec[IDX_W-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sp <= '0;
    else if (push && !full) r_sp <= r_sp + SP_W'(1);
    else if (pop && !empty) r_sp <= w_sp_dec;
  end
  always_ff @(posedge clk) begin
    if (push && !full) r_mem[r_sp[IDX_W-1:0]] <= din;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/issue/execute PC control FSM; `define PC_STACK_EN adds a 4-entry call/ret stack
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = RESET_VEC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_rdata,
  output logic [7:0]        instr_out,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic [ADDR_W-1:0] target,
  input  logic              call,
  input  logic              ret,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic              wrapped,
  output logic              stack_err
);
  state_t r_state, w_next;
  npc_t w_sel;
  logic [ADDR_W-1:0] r_pc, w_inc, w_npc, w_top;
  logic [7:0] r_instr;
  logic r_wrapped, r_seen_low, w_go, w_restart;
  assign w_go = (r_state == S_EXEC) && exec_done;
  assign w_restart = (r_state == S_HALT) && r_seen_low && run;
  assign w_inc = r_pc + ADDR_W'(1);
`ifdef PC_STACK_EN
  logic w_full, w_empty, w_push, w_pop, r_stack_err;
  assign w_push = w_go && !halt_req && !ret && call && !w_full;
  assign w_pop = w_go && !halt_req && ret && !w_empty;
  assign w_sel = halt_req ? NPC_HOLD : ret ? (w_empty ? NPC_INC : NPC_RET) :
                 call ? (w_full ? NPC_INC : NPC_TGT) : (jump || branch_taken) ? NPC_TGT : NPC_INC;
  pc_ret_stack #(.W(ADDR_W)) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_inc),
    .dout  (w_top),
    .full  (w_full),
    .empty (w_empty)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stack_err <= 1'b0;
    else if (w_go && !halt_req && (ret ? w_empty : call && w_full)) r_stack_err <= 1'b1;
  end
  assign stack_err = r_stack_err;
`else
  // Without the stack a call is a plain jump and a ret just falls through
  assign w_sel = halt_req ? NPC_HOLD : ret ? NPC_INC :
                 (call || jump || branch_taken) ? NPC_TGT : NPC_INC;
  assign w_top = w_inc;
  assign stack_err = 1'b0;
`endif
  assign w_npc = (w_sel == NPC_TGT) ? target : (w_sel == NPC_RET) ? w_top :
                 (w_sel == NPC_HOLD) ? r_pc : w_inc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = run ? S_FETCH : S_IDLE;
      S_FETCH: w_next = imem_ack ? S_ISSUE : S_FETCH;
      S_ISSUE: w_next = S_EXEC;
      S_EXEC:  w_next = !exec_done ? S_EXEC : halt_req ? S_HALT : run ? S_FETCH : S_IDLE;
      S_HALT:  w_next = w_restart ? S_FETCH : S_HALT;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    imem_req = r_state == S_FETCH;
    instr_valid = r_state == S_ISSUE;
    halted = r_state == S_HALT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_VEC;
      r_instr <= 8'h00;
      r_wrapped <= 1'b0;
      r_seen_low <= 1'b0;
    end else begin
      r_seen_low <= (r_state == S_HALT) && (r_seen_low || !run);
      if (r_state == S_FETCH && imem_ack) r_instr <= imem_rdata;
      if (w_restart) begin
        r_pc <= RESET_VEC;
        r_wrapped <= 1'b0;
      end else if (w_go) begin
        r_pc <= w_npc;
        if (w_sel == NPC_INC && r_pc == '1) r_wrapped <= 1'b1;
      end
    end
  end
  assign imem_addr = r_pc;
  assign pc_out = r_pc;
  assign instr_out = r_instr;
  assign wrapped = r_wrapped;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector self-checking bench for pc_sequencer
module tb_pc_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic imem_req, imem_ack = 1'b0, instr_valid, exec_done = 1'b0;
  logic branch_taken = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0, halt_req = 1'b0;
  logic halted, wrapped, stack_err;
  logic [7:0] imem_addr, imem_rdata = 8'h00, instr_out, target = 8'h00, pc_out, p;
  int n_chk = 0, n_pass = 0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_out(instr_out),
    .instr_valid(instr_valid), .exec_done(exec_done), .branch_taken(branch_taken),
    .jump(jump), .target(target), .call(call), .ret(ret), .halt_req(halt_req),
    .pc_out(pc_out), .halted(halted), .wrapped(wrapped), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One instruction: fetch at address a (zero-wait), issue d, then exec_done with controls
  task automatic run_instr(input logic [7:0] a, input logic [7:0] d, input logic h, input logic r,
                           input logic c, input logic j, input logic b, input logic [7:0] t);
    for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
    chk("imem_req", imem_req, 1);
    chk("imem_addr", imem_addr, a);
    imem_ack = 1'b1;
    imem_rdata = d;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("instr_valid_hi", instr_valid, 1);
    chk("instr_out", instr_out, d);
    @(negedge clk);
    chk("instr_valid_lo", instr_valid, 0);
    exec_done = 1'b1;
    {halt_req, ret, call, jump, branch_taken, target} = {h, r, c, j, b, t};
    @(negedge clk);
    exec_done = 1'b0;
    {halt_req, ret, call, jump, branch_taken, target} = '0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc_out, 8'h00);
    chk("rst_instr", instr_out, 8'h00);
    chk("rst_flags", {instr_valid, halted, wrapped, stack_err}, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run_instr(8'h00, 8'hA5, 0, 0, 0, 0, 0, 8'h00);
    run_instr(8'h01, 8'hA5, 0, 0, 0, 0, 0, 8'h00);
    run_instr(8'h02, 8'hA5, 0, 0, 0, 0, 0, 8'h00);
    // exec_done while fetching must be ignored
    exec_done = 1'b1;
    jump = 1'b1;
    target = 8'hEE;
    @(negedge clk);
    {exec_done, jump, target} = '0;
    chk("ignored_done_pc", pc_out, 8'h03);
    chk("ignored_done_req", imem_req, 1);
    run_instr(8'h03, 8'h11, 0, 0, 0, 1, 1, 8'h40);
    run_instr(8'h40, 8'h22, 0, 0, 0, 0, 1, 8'h10);
`ifdef PC_STACK_EN
    run_instr(8'h10, 8'h33, 0, 0, 1, 0, 0, 8'h30);
    run_instr(8'h30, 8'h44, 0, 1, 0, 0, 0, 8'h00);
    run_instr(8'h11, 8'h55, 0, 0, 1, 0, 0, 8'h20);
    run_instr(8'h20, 8'h55, 0, 0, 1, 0, 0, 8'h21);
    run_instr(8'h21, 8'h55, 0, 0, 1, 0, 0, 8'h22);
    run_instr(8'h22, 8'h55, 0, 0, 1, 0, 0, 8'h23);
    chk("stack_err_full_ok", stack_err, 0);
    run_instr(8'h23, 8'h55, 0, 0, 1, 0, 0, 8'h60);
    chk("stack_err_overflow", stack_err, 1);
    run_instr(8'h24, 8'h66, 0, 1, 0, 0, 0, 8'h00);
    run_instr(8'h23, 8'h66, 0, 1, 0, 0, 0, 8'h00);
    run_instr(8'h22, 8'h66, 0, 1, 0, 0, 0, 8'h00);
    run_instr(8'h21, 8'h66, 0, 1, 0, 0, 0, 8'h00);
    run_instr(8'h12, 8'h66, 0, 1, 0, 0, 0, 8'h00);
    chk("stack_err_underflow", stack_err, 1);
    p = 8'h13;
`else
    run_instr(8'h10, 8'h33, 0, 0, 1, 0, 0, 8'h30);
    run_instr(8'h30, 8'h44, 0, 1, 0, 0, 0, 8'h00);
    chk("stack_err_off", stack_err, 0);
    p = 8'h31;
`endif
    run_instr(p, 8'h77, 0, 0, 0, 1, 0, 8'hFF);
    chk("wrapped_before", wrapped, 0);
    run_instr(8'hFF, 8'h77, 0, 0, 0, 0, 0, 8'h00);
    chk("wrapped_first", wrapped, 1);
    run_instr(8'h00, 8'h77, 0, 0, 0, 1, 0, 8'hFF);
    run_instr(8'hFF, 8'h77, 0, 0, 0, 0, 0, 8'h00);
    chk("wrapped_second", wrapped, 1);
    run_instr(8'h00, 8'h88, 0, 0, 0, 0, 0, 8'h00);
    run_instr(8'h01, 8'h88, 1, 0, 0, 1, 0, 8'h77);
    chk("halted", halted, 1);
    chk("halt_pc", pc_out, 8'h01);
    repeat (2) @(negedge clk);
    chk("halt_no_req", imem_req, 0);
    chk("halt_holds_run_high", halted, 1);
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    chk("restart_halted", halted, 0);
    chk("restart_pc", pc_out, 8'h00);
    chk("restart_wrapped", wrapped, 0);
    run_instr(8'h00, 8'h99, 0, 0, 0, 0, 0, 8'h00);
    repeat (3) begin
      @(negedge clk);
      chk("ack_wait_req", imem_req, 1);
    end
    chk("ack_wait_pc", pc_out, 8'h01);
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    chk("async_rst_req", imem_req, 0);
    chk("async_rst_pc", pc_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 8'h3C;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_ack_instr", instr_out, 8'h00);
    chk("late_ack_valid", instr_valid, 0);
    chk("late_ack_req", imem_req, 0);
    run = 1'b1;
    @(negedge clk);
    run_instr(8'h00, 8'h5A, 0, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    chk("final_addr", imem_addr, 8'h01);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
